result_arbiter: RTL
===================

# result_arbiter

Shares the single reorder-buffer write port between the execution units (ITU, LSU, CSR, FPU) that complete out of order behind the scheduler. Each unit pushes finished results into a private 2-entry buffer. A round-robin arbiter then drains one result per cycle into a registered output stage. When the ROB back-pressures, results queue up and each unit's ready drops once its buffer is full, so the unit stalls.

## Interface
- `N_REQ`, default 4: number of requesting units; index 0=ITU, 1=LSU, 2=CSR, 3=FPU.
- `ROB_DEPTH`, default 32: ROB entries; tag width is `$clog2(ROB_DEPTH)`.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset; asynchronous, active-low. Clock is `clk_i`.
- `flush_i` in 1: synchronous pipeline flush.
- `valid_i` in `N_REQ`: unit i presents a result this cycle.
- `ready_o` out `N_REQ`: buffer i accepts a result; it is high when buffer i is not full.
- `result_i` in `N_REQ` x `rob_result_t`: fields are `result` (32), `rob_tag`, `reg_dest` (5), `exception_generated` (1), `exception_vector` (5).
- `rob_write_o` out 1: the output stage holds a valid result.
- `rob_result_o` out `rob_result_t`: the result being written to the ROB.
- `rob_ready_i` in 1: the ROB accepts `rob_result_o` this cycle.

## Operation
- **Push rule:** a push into buffer i happens when `valid_i[i] & ready_o[i]`. When `ready_o[i]=0`, `valid_i[i]` is ignored; the unit must hold its result.
- **Buffers:** each buffer is a 2-entry FIFO with a 2-bit count plus read/write pointers. A simultaneous push and pop on a count-1 buffer leaves the count at 1.
- **`ready_o` source:** `ready_o[i]` is derived from the registered count only, so there is no combinational path from `rob_ready_i`.
- **Output stage:** a single register. It loads when `!rob_write_o | rob_ready_i` and at least one buffer is non-empty.
- **Grant selection:** the grant goes to the first non-empty buffer at index ≥ `rr_ptr`, wrapping modulo `N_REQ`. The granted buffer pops in that same cycle.
- **`rr_ptr` update:** on a grant to index g, `rr_ptr` becomes `(g+1) mod N_REQ`. It holds when there is no grant.
- **Draining the output:** if `rob_ready_i` is high, no buffer is non-empty, and `rob_write_o` is high, then `rob_write_o` clears.
- **Flush:** `flush_i` empties all buffers, clears `rob_write_o` and sets `rr_ptr=0` at the next edge. Pushes and grants in the flush cycle are discarded.
- **Reset:** all counts and pointers are 0, `rob_write_o=0`, `rob_result_o='0`, `rr_ptr=0`. As a result, `ready_o` is all ones.
- **Stability under back-pressure:** `rob_result_o` stays stable while `rob_write_o & !rob_ready_i`.
- **Ordering:** within one unit, results leave in push order. There is no ordering guarantee across units; the ROB reorders by tag.

## Timing
- **Minimum latency:** a result pushed at edge t appears on `rob_write_o` in the cycle after edge t+1 (two cycles).
- **Throughput:** one result per cycle sustained when `rob_ready_i=1`.
- **Fairness bound:** with all buffers non-empty, unit i waits at most `N_REQ-1` grants.
- **`ready_o` after a full buffer:** when buffer i is full and pops at edge t, `ready_o[i]` rises in the cycle after t.
- **Full-buffer push:** a push arriving in that same cycle is refused and must be retried.
- **Reset mid-operation:** asynchronous assertion clears everything immediately. Deassertion is synchronised externally.

## Structure
- **Shared package (`apogeo_pkg`):**
  - typedef `rob_result_t`;
  - requester index constants `ITU_REQ`, `LSU_REQ`, `CSR_REQ`, `FPU_REQ`.
- **Sub-module `result_buffer`:** the 2-entry FIFO with `push`, `pop`, `flush`, `full`, `empty` and `head` data. It is instantiated `N_REQ` times via generate.
- **Top level:** holds the round-robin select, `rr_ptr` and the output register. Target is roughly 200 lines in total.

## Test plan
1. **Reset:** assert `rst_n_i` low mid-traffic.
   - `rob_write_o=0` immediately and `ready_o=4'b1111`.
   - After release, the first result pushed with `rob_tag=5` appears 2 cycles later.
2. **Round-robin:** `rob_ready_i=1`; all four units push once in the same cycle with tags 1, 2, 3, 4.
   - Output order is tags 1, 2, 3, 4 on consecutive cycles.
   - A second round with `rr_ptr=2` forced yields the order 3, 4, 1, 2.
3. **Back-pressure:** `rob_ready_i=0`; LSU pushes tags 7, 8, 9.
   - Tag 7 sits in the output register and tag 8 in the buffer.
   - Tag 9 is also buffered.
   - Afterwards `ready_o[1]=0` and `rob_result_o` stays stable.
   - Raising `rob_ready_i` delivers 7, 8, 9 in order.
4. **Flush:** three units have pending results and `flush_i` pulses with `valid_i[0]` high.
   - Next cycle: `rob_write_o=0`, all buffers empty, `ready_o=4'b1111`.
   - The ITU push is lost.
5. **Simultaneous push/pop:** CSR buffer has count 1; push tag 12 and grant CSR in the same cycle.
   - Count stays 1 and tag 12 is output next.
   - `ready_o[2]` never drops.
6. **Exception passthrough:** FPU pushes with `exception_generated=1` and `exception_vector=5'd2`.
   - Output carries identical fields along with `reg_dest` and `rob_tag`.

Source files
------------

// File: rtl/apogeo_pkg.sv
// Shared types for the result arbiter: the ROB result record and the
// requester index assignment of the execution units.
package apogeo_pkg;

   localparam int ROB_DEPTH_DEF = 32;
   localparam int TAG_W         = $clog2(ROB_DEPTH_DEF);

   localparam int ITU_REQ = 0;
   localparam int LSU_REQ = 1;
   localparam int CSR_REQ = 2;
   localparam int FPU_REQ = 3;

   typedef struct packed {
      logic [31:0]      result;
      logic [TAG_W-1:0] rob_tag;
      logic [4:0]       reg_dest;
      logic             exception_generated;
      logic [4:0]       exception_vector;
   } rob_result_t;

endpackage

// File: rtl/result_buffer.sv
// Two-entry FIFO holding finished results of one execution unit.
// Ports: clk_i/rst_n_i clock and async active-low reset, flush_i empties the
// buffer, push_i/data_i write (ignored when full), pop_i read (ignored when
// empty), full_o/empty_o status from the registered count, head_o oldest entry.
module result_buffer
   import apogeo_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        flush_i,
   input  logic        push_i,
   input  rob_result_t data_i,
   input  logic        pop_i,
   output logic        full_o,
   output logic        empty_o,
   output rob_result_t head_o
);

   logic [1:0]  r_count;
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   rob_result_t r_mem [2];

   logic w_push;
   logic w_pop;

   assign full_o  = (r_count == 2'd2);
   assign empty_o = (r_count == 2'd0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign head_o  = r_mem[r_rd_ptr];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else if (flush_i) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
   end

endmodule

// File: rtl/result_arbiter.sv
// Shares the single ROB write port among N_REQ execution units. Each unit
// fills a private 2-entry buffer; a round-robin arbiter moves one result per
// cycle into a registered output stage that the ROB drains with rob_ready_i.
// Ports: clk_i/rst_n_i clock and async active-low reset, flush_i synchronous
// flush, valid_i/ready_o/result_i per-unit push handshake, rob_write_o/
// rob_result_o/rob_ready_i output handshake towards the ROB.
module result_arbiter
   import apogeo_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    flush_i,
   input  logic [N_REQ-1:0]        valid_i,
   output logic [N_REQ-1:0]        ready_o,
   input  rob_result_t [N_REQ-1:0] result_i,
   output logic                    rob_write_o,
   output rob_result_t             rob_result_o,
   input  logic                    rob_ready_i
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // The record layout is fixed in the package, so the tag width must agree.
   if ($clog2(ROB_DEPTH) != TAG_W) begin : g_bad_rob_depth
      $error("ROB_DEPTH does not match rob_result_t tag width");
   end

   logic [N_REQ-1:0]        w_full;
   logic [N_REQ-1:0]        w_empty;
   logic [N_REQ-1:0]        w_push;
   logic [N_REQ-1:0]        w_pop;
   rob_result_t [N_REQ-1:0] w_head;

   logic             w_can_load;
   logic             w_gnt_valid;
   logic [PTR_W-1:0] w_gnt_idx;
   logic             w_load;

   logic [PTR_W-1:0] r_rr_ptr;
   logic             r_rob_write;
   rob_result_t      r_rob_result;

   // ready comes from the registered count only, never from rob_ready_i.
   assign ready_o = ~w_full;
   assign w_push  = valid_i & ~w_full;

   for (genvar i = 0; i < N_REQ; i++) begin : g_buf
      result_buffer u_buf (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .flush_i (flush_i),
         .push_i  (w_push[i]),
         .data_i  (result_i[i]),
         .pop_i   (w_pop[i]),
         .full_o  (w_full[i]),
         .empty_o (w_empty[i]),
         .head_o  (w_head[i])
      );
   end

   // First non-empty buffer at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      idx         = 0;
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(r_rr_ptr) + k) % N_REQ;
         if (!w_gnt_valid && !w_empty[idx]) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = PTR_W'(idx);
         end
      end
   end

   assign w_can_load = ~r_rob_write | rob_ready_i;
   assign w_load     = w_can_load & w_gnt_valid;

   always_comb begin
      w_pop = '0;
      if (w_load) w_pop[w_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rr_ptr     <= '0;
         r_rob_write  <= 1'b0;
         r_rob_result <= '0;
      end else if (flush_i) begin
         r_rr_ptr    <= '0;
         r_rob_write <= 1'b0;
      end else if (w_load) begin
         r_rr_ptr     <= PTR_W'((int'(w_gnt_idx) + 1) % N_REQ);
         r_rob_write  <= 1'b1;
         r_rob_result <= w_head[w_gnt_idx];
      end else if (rob_ready_i) begin
         r_rob_write <= 1'b0;
      end
   end

   assign rob_write_o  = r_rob_write;
   assign rob_result_o = r_rob_result;

endmodule
